// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    StSettle,
    StIdle,
    StGate
  } state_e;

  localparam int unsigned SETTLE_CYCLES = 3;

  // Increment val by inc, holding at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc,
                                          input logic [31:0] max_val);
    if (inc && (val != max_val)) return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer for an asynchronous input with a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic CLEARn,
  input  logic din,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (!CLEARn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s1 may be metastable; the edge is taken from the settled pair.
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clk cycles and
// publishes the count with a one-cycle valid strobe.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned GATE_W      = 26,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             CLEARn,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);
  import freq_meter_pkg::*;

  localparam logic [GATE_W-1:0] WinLast = GATE_W'(GATE_CYCLES - 1);
  localparam logic [31:0]       CntMax  = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [1:0]        SettleLast = 2'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        settle_q, settle_d;
  logic [GATE_W-1:0] win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              rise;
  logic              terminal;
  logic              cnt_full;

  sync_edge_det u_sync (
    .clk    (clk),
    .CLEARn (CLEARn),
    .din    (sig_in),
    .rise   (rise)
  );

  assign terminal = (state_q == StGate) && (win_q == WinLast);
  assign cnt_full = (32'(cnt_q) == CntMax);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    freq_d   = freq_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    case (state_q)
      StSettle: begin
        // Lets a sig_in held high through reset pass the edge detector unseen.
        if (settle_q == SettleLast) begin
          settle_d = '0;
          state_d  = StIdle;
        end else begin
          settle_d = settle_q + 2'd1;
        end
      end
      StIdle: begin
        win_d = '0;
        cnt_d = '0;
        acc_d = 1'b0;
        if (en) state_d = StGate;
      end
      StGate: begin
        if (terminal) begin
          freq_d  = CNT_W'(sat_inc(32'(cnt_q), rise, CntMax));
          ovf_d   = acc_q | (rise & cnt_full);
          valid_d = 1'b1;
          win_d   = '0;
          cnt_d   = '0;
          acc_d   = 1'b0;
          if (!en) state_d = StIdle;
        end else if (!en) begin
          win_d   = '0;
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = StIdle;
        end else begin
          win_d = win_q + 1'b1;
          cnt_d = CNT_W'(sat_inc(32'(cnt_q), rise, CntMax));
          acc_d = acc_q | (rise & cnt_full);
        end
      end
      default: state_d = StSettle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!CLEARn) begin
      state_q  <= StSettle;
      settle_q <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      freq_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign freq_out = freq_q;
  assign valid    = valid_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q == StGate);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle window and a 4-bit edge counter.
module tb_freq_meter;

  localparam int unsigned GateCycles = 100;

  logic       clk = 1'b0;
  logic       CLEARn = 1'b0;
  logic       en = 1'b0;
  logic       sig_in;
  logic [3:0] freq_out;
  logic       valid;
  logic       ovf;
  logic       busy;

  int   n_checks = 0;
  int   n_fail = 0;
  int   half = 0;
  logic hold_lvl = 1'b0;

  freq_meter #(
    .GATE_CYCLES (GateCycles),
    .GATE_W      (7),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .CLEARn   (CLEARn),
    .en       (en),
    .sig_in   (sig_in),
    .freq_out (freq_out),
    .valid    (valid),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Square-wave source: half-period of 'half' clk cycles, or static hold_lvl when half is 0.
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (half == 0) begin
        sig_in = hold_lvl;
        ph = 0;
      end else begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          sig_in = ~sig_in;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedges until valid is seen (n = 1 on the first negedge).
  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < budget);
    check({tag, " valid seen"}, 32'(valid), 32'd1);
  endtask

  initial begin
    int n;
    logic seen;

    // sig_in high through reset with en already high.
    hold_lvl = 1'b1;
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("reset freq_out", 32'(freq_out), 0);
    check("reset valid", 32'(valid), 0);
    check("reset ovf", 32'(ovf), 0);
    check("reset busy", 32'(busy), 0);
    CLEARn = 1'b1;
    wait_valid("hi_thru_reset", 300, n);
    check("hi_thru_reset freq", 32'(freq_out), 0);
    check("hi_thru_reset ovf", 32'(ovf), 0);

    // Period 10: 10 edges per window, strobes 100 cycles apart.
    half = 5;
    wait_valid("p10 skip", 150, n);
    wait_valid("p10 w1", 150, n);
    check("p10 spacing", 32'(n), 100);
    check("p10 w1 freq", 32'(freq_out), 10);
    check("p10 w1 ovf", 32'(ovf), 0);
    @(negedge clk);
    check("valid one cycle", 32'(valid), 0);
    wait_valid("p10 w2", 150, n);
    check("p10 w2 freq", 32'(freq_out), 10);

    // Period 2 saturates the 4-bit counter; period 20 then reads 5.
    half = 1;
    wait_valid("p2 skip", 150, n);
    wait_valid("p2", 150, n);
    check("p2 freq sat", 32'(freq_out), 15);
    check("p2 ovf", 32'(ovf), 1);
    half = 10;
    wait_valid("p20 skip", 150, n);
    wait_valid("p20", 150, n);
    check("p20 freq", 32'(freq_out), 5);
    check("p20 ovf", 32'(ovf), 0);

    // Abort at window cycle 50, then a fresh full window.
    half = 5;
    en = 1'b0;
    repeat (30) @(negedge clk);
    check("idle busy", 32'(busy), 0);
    en = 1'b1;
    repeat (50) @(negedge clk);
    check("gate busy", 32'(busy), 1);
    en = 1'b0;
    @(negedge clk);
    check("abort busy fall", 32'(busy), 0);
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      seen |= valid;
    end
    check("abort no valid", 32'(seen), 0);
    check("abort freq kept", 32'(freq_out), 5);
    check("abort ovf kept", 32'(ovf), 0);
    en = 1'b1;
    wait_valid("restart", 200, n);
    check("restart latency", 32'(n), 101);
    check("restart freq", 32'(freq_out), 10);

    // Three early pulses plus one edge detected in the terminal cycle.
    en = 1'b0;
    half = 0;
    hold_lvl = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 98; k++) begin
      @(negedge clk);
      case (k)
        10, 20, 30, 98: hold_lvl = 1'b1;
        15, 25, 35:     hold_lvl = 1'b0;
        default: ;
      endcase
    end
    wait_valid("term", 10, n);
    check("term latency", 32'(n), 3);
    check("term freq", 32'(freq_out), 4);
    check("term ovf", 32'(ovf), 0);
    wait_valid("after term", 150, n);
    check("after term spacing", 32'(n), 100);
    check("after term freq", 32'(freq_out), 0);

    // One-cycle reset mid-window.
    half = 5;
    wait_valid("pre reset skip", 150, n);
    wait_valid("pre reset", 150, n);
    check("pre reset freq", 32'(freq_out), 10);
    repeat (30) @(negedge clk);
    CLEARn = 1'b0;
    @(negedge clk);
    CLEARn = 1'b1;
    check("midreset freq", 32'(freq_out), 0);
    check("midreset ovf", 32'(ovf), 0);
    check("midreset valid", 32'(valid), 0);
    check("midreset busy", 32'(busy), 0);
    n = 1;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("settle busy delay", 32'(n), 5);
    wait_valid("post reset", 150, n);
    check("post reset spacing", 32'(n), 100);
    check("post reset freq", 32'(freq_out), 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
